// File: rtl/x_bank_pkg.sv
// Shared parameter defaults and controller state encoding for the multi-channel SPI SRAM bank controller.
package x_bank_pkg;
    localparam int NUM_CH_DEF = 16;
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;
    localparam int TO_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/x_bank_lane.sv
// One channel's accept / completion / read-data tracker; state updates on the clock edge after its inputs.
// Handshake bits are only honoured while busy, so stray pulses in idle or response phases are dropped.
module x_bank_lane
    import x_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_mask,
    input  logic              busy,
    input  logic              abort,
    input  logic              mask,
    input  logic              rd_n_wr,
    input  logic              accept,
    input  logic              ready,
    input  logic [DATA_W-1:0] ch_data,
    output logic              pend,
    output logic              done,
    output logic              hit,
    output logic [DATA_W-1:0] lane_data
);
    logic take;
    logic accepted;

    // A targeted lane with no pending request has already been accepted this command.
    assign take     = busy && pend && accept;
    assign accepted = (mask && !pend) || take;
    assign hit      = busy && mask && ready && accepted && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            done      <= 1'b0;
            lane_data <= '0;
        end else if (start) begin
            pend      <= start_mask;
            done      <= 1'b0;
            lane_data <= '0;
        end else if (busy) begin
            if (take || abort) begin
                pend <= 1'b0;
            end
            if (hit) begin
                done <= 1'b1;
                if (rd_n_wr) begin
                    lane_data <= ch_data;
                end
            end
        end
    end
endmodule

// File: rtl/x_bank_ctrl.sv
// Broadcasts one read/write command to a masked set of SRAM channels and gathers a combined response.
// Min latency 2 cycles command-to-response; response held until i_rsp_ready, new command accepted only in IDLE.
module x_bank_ctrl
    import x_bank_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TO_W   = TO_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_rd_n_wr,
    input  logic [ADDR_W-1:0]        i_cmd_addr,
    input  logic [DATA_W-1:0]        i_cmd_wdata,
    input  logic [NUM_CH-1:0]        i_cmd_mask,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [NUM_CH*DATA_W-1:0] o_rsp_rdata,
    output logic [NUM_CH-1:0]        o_rsp_done,
    output logic [NUM_CH-1:0]        o_rsp_mismatch,
    output logic                     o_rsp_timeout,
    output logic [NUM_CH-1:0]        o_valid,
    input  logic [NUM_CH-1:0]        i_accept,
    output logic                     o_rd_n_wr,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [DATA_W-1:0]        o_wdata,
    input  logic [NUM_CH-1:0]        i_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_rdata
);
    state_t              state;
    logic                cmd_rd_n_wr;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [NUM_CH-1:0]   cmd_mask;
    logic [TO_W-1:0]     to_cnt;
    logic [TO_W-1:0]     to_next;
    logic                rsp_timeout;
    logic                capture;
    logic                busy;
    logic                expire;
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   done;
    logic [NUM_CH-1:0]   hit;
    logic [DATA_W-1:0]   lane_data [NUM_CH];
    logic                found;
    logic [DATA_W-1:0]   ref_data;
    logic [NUM_CH-1:0]   mismatch;

    assign capture = (state == ST_IDLE) && i_cmd_valid;
    assign busy    = (state == ST_BUSY);
    assign to_next = to_cnt + TO_W'(1);
    assign expire  = busy && (&to_next);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        x_bank_lane #(.DATA_W(DATA_W)) u_lane (
            .clk        (i_clk),
            .rst_n      (i_rst),
            .start      (capture),
            .start_mask (i_cmd_mask[g]),
            .busy       (busy),
            .abort      (expire),
            .mask       (cmd_mask[g]),
            .rd_n_wr    (cmd_rd_n_wr),
            .accept     (i_accept[g]),
            .ready      (i_ready[g]),
            .ch_data    (i_rdata[g*DATA_W +: DATA_W]),
            .pend       (pend[g]),
            .done       (done[g]),
            .hit        (hit[g]),
            .lane_data  (lane_data[g])
        );
    end

    // Reference for mismatch is the lowest-indexed lane that completed.
    always_comb begin
        found    = 1'b0;
        ref_data = '0;
        mismatch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (done[i] && !found) begin
                found    = 1'b1;
                ref_data = lane_data[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            mismatch[i] = cmd_rd_n_wr && done[i] && (lane_data[i] != ref_data);
        end
    end

    always_comb begin
        o_rsp_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_rsp_rdata[i*DATA_W +: DATA_W] = lane_data[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            cmd_rd_n_wr <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_mask    <= '0;
            to_cnt      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_rd_n_wr <= i_cmd_rd_n_wr;
                        cmd_addr    <= i_cmd_addr;
                        cmd_wdata   <= i_cmd_wdata;
                        cmd_mask    <= i_cmd_mask;
                        to_cnt      <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= (i_cmd_mask == '0) ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    to_cnt <= to_next;
                    // Timeout wins even if the last lane completes on the same edge.
                    if (&to_next) begin
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else if ((done | hit) == cmd_mask) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready    = (state == ST_IDLE);
    assign o_rsp_valid    = (state == ST_RESP);
    assign o_rsp_done     = done;
    assign o_rsp_mismatch = mismatch;
    assign o_rsp_timeout  = rsp_timeout;
    assign o_valid        = pend;
    assign o_rd_n_wr      = cmd_rd_n_wr;
    assign o_addr         = cmd_addr;
    assign o_wdata        = cmd_wdata;
endmodule

// File: tb/tb_x_bank_ctrl.sv
// Randomized and directed checks of x_bank_ctrl against a per-command behavioural model.
module tb_x_bank_ctrl;
    localparam int N      = 16;
    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int TW     = 4;
    localparam int TO_LIM = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_rd;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [N-1:0]  cmd_mask;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [N*DW-1:0] rsp_rdata;
    logic [N-1:0]  rsp_done, rsp_mismatch;
    logic [N-1:0]  ch_valid, ch_accept, ch_ready;
    logic          ch_rd;
    logic [AW-1:0] ch_addr;
    logic [DW-1:0] ch_wdata;
    logic [N*DW-1:0] ch_rdata;

    always #5 clk = ~clk;

    x_bank_ctrl #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TO_W(TW)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rd_n_wr(cmd_rd),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_mask(cmd_mask),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_done(rsp_done), .o_rsp_mismatch(rsp_mismatch), .o_rsp_timeout(rsp_timeout),
        .o_valid(ch_valid), .i_accept(ch_accept), .o_rd_n_wr(ch_rd), .o_addr(ch_addr),
        .o_wdata(ch_wdata), .i_ready(ch_ready), .i_rdata(ch_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Model: 0 = waiting for command, 1 = collecting lanes, 2 = response offered.
    int            phase;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  m_mask, m_acc, m_done;
    logic [DW-1:0] m_rdata [N];
    int            m_cycles;
    logic          m_to;
    int            rsp_count;

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0; m_rd = 1'b0; m_addr = '0; m_wdata = '0;
        m_mask = '0; m_acc = '0; m_done = '0; m_cycles = 0; m_to = 1'b0;
        for (int i = 0; i < N; i++) m_rdata[i] = '0;
    endtask

    function automatic logic [N*DW-1:0] exp_rdata();
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m_rdata[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_mismatch();
        logic [N-1:0] v;
        int first;
        v = '0;
        first = -1;
        for (int i = N - 1; i >= 0; i--) if (m_done[i]) first = i;
        if (m_rd && first >= 0)
            for (int i = 0; i < N; i++) v[i] = m_done[i] && (m_rdata[i] != m_rdata[first]);
        return v;
    endfunction

    task automatic compare();
        check("cmd_ready", cmd_ready, phase == 0);
        check("ch_valid", ch_valid, (phase == 1) ? (m_mask & ~m_acc) : '0);
        check("rsp_valid", rsp_valid, phase == 2);
        check("cmd_bus", {ch_rd, ch_addr, ch_wdata}, {m_rd, m_addr, m_wdata});
        if (phase == 2) begin
            check("rsp_done", rsp_done, m_done);
            check("rsp_rdata", rsp_rdata, exp_rdata());
            check("rsp_mismatch", rsp_mismatch, exp_mismatch());
            check("rsp_timeout", rsp_timeout, m_to);
        end
    endtask

    task automatic model_step();
        logic acc_now;
        case (phase)
            0: if (cmd_valid) begin
                m_rd = cmd_rd; m_addr = cmd_addr; m_wdata = cmd_wdata; m_mask = cmd_mask;
                m_acc = '0; m_done = '0; m_cycles = 0; m_to = 1'b0;
                for (int i = 0; i < N; i++) m_rdata[i] = '0;
                phase = (cmd_mask == '0) ? 2 : 1;
            end
            1: begin
                m_cycles++;
                for (int i = 0; i < N; i++) begin
                    if (m_mask[i]) begin
                        acc_now = m_acc[i] || ch_accept[i];
                        if (acc_now && ch_ready[i] && !m_done[i]) begin
                            m_done[i] = 1'b1;
                            if (m_rd) m_rdata[i] = ch_rdata[i*DW +: DW];
                        end
                        m_acc[i] = acc_now;
                    end
                end
                if (m_cycles == TO_LIM) begin
                    m_to = 1'b1;
                    phase = 2;
                end else if (m_done == m_mask) begin
                    phase = 2;
                end
            end
            default: if (rsp_ready) begin
                phase = 0;
                rsp_count++;
            end
        endcase
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        if (!rst_n) model_reset();
        compare();
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        rsp_ready = 1'b0; ch_accept = '0; ch_ready = '0; ch_rdata = '0;
    endtask

    task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [N-1:0] m);
        cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_wdata = d; cmd_mask = m;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rand_inputs();
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_rd    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_mask  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
        rsp_ready = 1'($urandom);
        ch_accept = N'($urandom);
        ch_ready  = N'($urandom) & N'($urandom);
        for (int i = 0; i < N; i++)
            ch_rdata[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : 8'h5A;
    endtask

    initial begin
        logic [N*DW-1:0] exp_v;
        int n;
        int base;
        rsp_count = 0;
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        check("reset_valid", ch_valid, '0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        check("reset_cmd_ready", cmd_ready, 1'b1);

        // Broadcast write, accept in cycle 1, ready in cycle 3.
        issue(1'b0, 13'h0100, 8'h5A, 16'hFFFF);
        check("w_valid", ch_valid, 16'hFFFF);
        ch_accept = 16'hFFFF; tick();
        ch_accept = '0; tick();
        ch_ready = 16'hFFFF; tick();
        ch_ready = '0;
        check("w_rsp_valid", rsp_valid, 1'b1);
        check("w_done", rsp_done, 16'hFFFF);
        check("w_rdata", rsp_rdata, '0);
        check("w_timeout", rsp_timeout, 1'b0);
        check("w_bus", {ch_addr, ch_wdata}, {13'h0100, 8'h5A});
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Two-lane read with differing data, minimum latency.
        issue(1'b1, 13'h0100, 8'h00, 16'h0009);
        ch_accept = 16'h0009; ch_ready = 16'h0009;
        ch_rdata = '0; ch_rdata[7:0] = 8'h5A; ch_rdata[31:24] = 8'h5B;
        tick();
        ch_accept = '0; ch_ready = '0;
        exp_v = '0; exp_v[7:0] = 8'h5A; exp_v[31:24] = 8'h5B;
        check("r_latency", rsp_valid, 1'b1);
        check("r_done", rsp_done, 16'h0009);
        check("r_mismatch", rsp_mismatch, 16'h0008);
        check("r_rdata", rsp_rdata, exp_v);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Channel 2 never accepts: timeout after 15 busy cycles.
        issue(1'b1, 13'h0040, 8'h00, 16'h0004);
        ch_accept = 16'hFFFB; ch_ready = 16'hFFFF;
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        ch_accept = '0; ch_ready = '0;
        check("to_cycles", n, 15);
        check("to_flag", rsp_timeout, 1'b1);
        check("to_done", rsp_done, '0);
        check("to_valid_low", ch_valid, '0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Stray ready on untargeted channel 7, same-cycle accept+ready on channel 1.
        issue(1'b1, 13'h0002, 8'h00, 16'h0002);
        ch_accept = 16'h0082; ch_ready = 16'h0082;
        ch_rdata = '0; ch_rdata[15:8] = 8'h33; ch_rdata[63:56] = 8'h77;
        tick();
        ch_accept = '0; ch_ready = '0;
        exp_v = '0; exp_v[15:8] = 8'h33;
        check("s_done", rsp_done, 16'h0002);
        check("s_rdata", rsp_rdata, exp_v);
        check("s_mismatch", rsp_mismatch, '0);

        // Response held under backpressure.
        for (int i = 0; i < 10; i++) begin
            check("hold_done", rsp_done, 16'h0002);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Reset in the middle of a command.
        issue(1'b0, 13'h1FFF, 8'hC3, 16'h00FF);
        ch_accept = 16'h000F; tick(); ch_accept = '0;
        base = rsp_count;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ch_valid, '0);
        check("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_done}, '0);
        check("mid_rst_bus", {ch_rd, ch_addr, ch_wdata}, '0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        check("post_rst_count", rsp_count, base);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            rand_inputs();
            tick();
        end
        idle_inputs();
        rsp_ready = 1'b1; ch_accept = '1; ch_ready = '1;
        n = 0;
        while (phase != 0 && n < 40) begin tick(); n++; end
        check("drain", phase == 0, 1'b1);
        check("rand_responses_seen", rsp_count > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/x_bank_ctrl.md
X_BANK_CTRL -- requirements
Module: x_bank_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- NUM_CH, 16, number of SPI SRAM channels.
- ADDR_W, 13, SRAM byte address width.
- DATA_W, 8, data width per channel.
- TO_W, 16, timeout counter width.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports are i_clk and i_rst.
REQ-003 Ports SHALL be as follows, one per line: name  direction  width  meaning.
- i_clk  in  1  clock.
- i_rst  in  1  async active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_rd_n_wr  in  1  1=read, 0=write.
- i_cmd_addr  in  ADDR_W  byte address.
- i_cmd_wdata  in  DATA_W  write data, common to all channels.
- i_cmd_mask  in  NUM_CH  target channel mask.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed.
- o_rsp_rdata  out  NUM_CH*DATA_W  per-lane read data; lane i is bits [i*DATA_W +: DATA_W].
- o_rsp_done  out  NUM_CH  lanes that completed.
- o_rsp_mismatch  out  NUM_CH  read lanes differing from the reference lane.
- o_rsp_timeout  out  1  command aborted by timeout.
- o_valid  out  NUM_CH  per-channel request.
- i_accept  in  NUM_CH  per-channel request taken.
- o_rd_n_wr  out  1  shared channel command.
- o_addr  out  ADDR_W  shared channel address.
- o_wdata  out  DATA_W  shared channel write data.
- i_ready  in  NUM_CH  per-channel completion pulse.
- i_rdata  in  NUM_CH*DATA_W  per-channel read data, valid with i_ready.

Function
REQ-004 The controller SHALL use three states, IDLE, BUSY and RESP, with o_cmd_ready=1 only in IDLE.
REQ-005 In IDLE, the handshake i_cmd_valid&&o_cmd_ready SHALL, on that edge, capture rd_n_wr/addr/wdata/mask, set pend_acc=mask, clear done, rdata and the timeout counter, and go to BUSY; with mask==0 it SHALL go directly to RESP.
REQ-006 o_rd_n_wr/o_addr/o_wdata SHALL be driven from the captured registers and SHALL be stable from the capture edge until the next capture.
REQ-007 In BUSY, o_valid SHALL equal pend_acc; a pend_acc bit SHALL clear on the edge where i_accept of that bit is high; i_accept SHALL be ignored on bits where o_valid is low.
REQ-008 i_ready[i] SHALL set done[i] only when mask[i] is set and the channel has been accepted, on that cycle or earlier; ready pulses on untargeted or unaccepted channels SHALL be ignored.
REQ-009 On a read, o_rsp_rdata lane i SHALL load i_rdata lane i when done[i] is set; on a write, rdata lanes SHALL remain 0.
REQ-010 Accept and ready high in the same cycle on one channel SHALL record both.
REQ-011 BUSY SHALL go to RESP on the edge where done|newly_done equals mask.
REQ-012 The timeout counter SHALL increment each BUSY cycle. At all-ones it SHALL take precedence: go to RESP with o_rsp_timeout=1, clear pend_acc, and drop o_valid on the next cycle.
REQ-013 In RESP, o_rsp_valid SHALL be 1 and all response outputs SHALL be held until i_rsp_ready; the handshake edge SHALL return to IDLE.
REQ-014 The earliest new command SHALL be the cycle after the RESP handshake; command-to-response minimum latency SHALL be 2 cycles with accept and ready arriving in the first BUSY cycle.
REQ-015 For reads, o_rsp_mismatch[i] SHALL be 1 when done[i] is set and lane i differs from the lowest-indexed done lane; it SHALL be 0 for writes and for lanes without done.
REQ-016 i_ready/i_accept in IDLE or RESP SHALL have no effect.

Reset
REQ-017 While i_rst=0, the state SHALL be IDLE, and o_valid, pend_acc, done, rdata, mismatch, timeout, o_rsp_valid and the captured command registers SHALL be 0; o_cmd_ready SHALL be 1 after release.
REQ-018 Reset mid-command SHALL abandon it with no response emitted.

Structure
REQ-019 Package x_bank_pkg SHALL hold the state enum and the parameter defaults.
REQ-020 Per-channel accept/done/rdata tracking SHALL be one sub-module x_bank_lane, generated NUM_CH times.

Verification
REQ-021 Write 0x5A to addr 0x0100 with mask 0xFFFF, all channels accepting in cycle 1 and ready in cycle 3 -> one response, done=0xFFFF, rdata=0, timeout=0.
REQ-022 Read addr 0x0100 with mask 0x0009, lane 0 returns 0x5A and lane 3 returns 0x5B -> done=0x0009, mismatch=0x0008, rdata lane0=0x5A, lane3=0x5B.
REQ-023 Mask 0x0004 with channel 2 never accepting and TO_W=4 -> RESP after 15 BUSY cycles, timeout=1, done=0, o_valid low thereafter.
REQ-024 i_ready pulses on untargeted channel 7 plus accept and ready in the same cycle on channel 1 -> done=0x0002 only.
REQ-025 Hold i_rsp_ready=0 for 10 cycles -> outputs stable and o_cmd_ready=0; assert reset mid-BUSY -> all outputs 0 and no response.
